// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: bus widths, RV32I opcode/funct3
// encodings, control-word field offsets and the ID->EX bus layout.
package id_pkg;

    localparam int DATA_W      = 32;
    localparam int IF_ID_BUS_W = 64;
    localparam int BR_BUS_W    = 33;
    localparam int ID_EX_BUS_W = 160;
    localparam int CTRL_W      = 27;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_e;

    // Control word layout; bits above CTRL_JALR are reserved and read as zero.
    localparam int CTRL_ALU_LSB    = 0;
    localparam int CTRL_SRC1_PC    = 4;
    localparam int CTRL_SRC2_IMM   = 5;
    localparam int CTRL_LINK       = 6;
    localparam int CTRL_REG_WE     = 7;
    localparam int CTRL_MEM_RE     = 8;
    localparam int CTRL_MEM_WE     = 9;
    localparam int CTRL_FUNCT3_LSB = 10;
    localparam int CTRL_BRANCH     = 13;
    localparam int CTRL_JAL        = 14;
    localparam int CTRL_JALR       = 15;

    localparam int BUS_PC_LSB   = 0;
    localparam int BUS_IMM_LSB  = 32;
    localparam int BUS_RS1_LSB  = 64;
    localparam int BUS_RS2_LSB  = 96;
    localparam int BUS_RD_LSB   = 128;
    localparam int BUS_CTRL_LSB = 133;

endpackage

// File: rtl/id_decoder.sv
// Pure combinational RV32I decoder: instruction word to control word,
// sign-extended immediate and register-usage flags.
module id_decoder
    import id_pkg::*;
(
    input  logic [31:0]       inst,
    output logic [CTRL_W-1:0] ctrl,
    output logic [31:0]       imm,
    output logic              rs1_used,
    output logic              rs2_used,
    output logic              rd_used
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b5;
    alu_op_e    alu_op;
    imm_fmt_e   fmt;
    logic       known;
    logic       src1_pc, src2_imm, link, reg_we, mem_re, mem_we;
    logic       is_br, is_jal, is_jalr;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7b5   = inst[30];

    function automatic alu_op_e alu_sel(input logic [2:0] funct3, input logic alt);
        case (funct3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        alu_op   = ALU_ADD;
        fmt      = FMT_NONE;
        known    = 1'b1;
        src1_pc  = 1'b0;
        src2_imm = 1'b0;
        link     = 1'b0;
        reg_we   = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        is_br    = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OPC_LUI: begin
                fmt = FMT_U; reg_we = 1'b1; src2_imm = 1'b1; alu_op = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                fmt = FMT_U; reg_we = 1'b1; src1_pc = 1'b1; src2_imm = 1'b1;
            end
            OPC_JAL: begin
                fmt = FMT_J; reg_we = 1'b1; src1_pc = 1'b1; link = 1'b1; is_jal = 1'b1;
            end
            OPC_JALR: begin
                fmt = FMT_I; reg_we = 1'b1; src1_pc = 1'b1; link = 1'b1; is_jalr = 1'b1;
                rs1_used = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = FMT_B; is_br = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                fmt = FMT_I; reg_we = 1'b1; mem_re = 1'b1; src2_imm = 1'b1; rs1_used = 1'b1;
            end
            OPC_STORE: begin
                fmt = FMT_S; mem_we = 1'b1; src2_imm = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only the shift-right encoding uses inst[30] as an alternate select.
                fmt = FMT_I; reg_we = 1'b1; src2_imm = 1'b1; rs1_used = 1'b1;
                alu_op = alu_sel(f3, (f3 == F3_SR) && f7b5);
            end
            OPC_OP: begin
                reg_we = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                alu_op = alu_sel(f3, f7b5);
            end
            default: known = 1'b0;
        endcase
    end

    assign rd_used = reg_we;

    always_comb begin
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        ctrl = '0;
        ctrl[CTRL_ALU_LSB +: 4]    = alu_op;
        ctrl[CTRL_SRC1_PC]         = src1_pc;
        ctrl[CTRL_SRC2_IMM]        = src2_imm;
        ctrl[CTRL_LINK]            = link;
        ctrl[CTRL_REG_WE]          = reg_we;
        ctrl[CTRL_MEM_RE]          = mem_re;
        ctrl[CTRL_MEM_WE]          = mem_we;
        ctrl[CTRL_FUNCT3_LSB +: 3] = known ? f3 : 3'b000;
        ctrl[CTRL_BRANCH]          = is_br;
        ctrl[CTRL_JAL]             = is_jal;
        ctrl[CTRL_JALR]            = is_jalr;
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: holds one instruction, resolves RAW hazards by
// stalling, resolves branches/jumps at handoff and redirects fetch.
module id_stage
    import id_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_to_id_valid,
    input  logic [IF_ID_BUS_W-1:0] if_to_id_bus,
    output logic                   id_allow_in,
    output logic                   id_valid,
    output logic [BR_BUS_W-1:0]    br_bus,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic [5:0]             ex_dest,
    input  logic [5:0]             mem_dest,
    input  logic [5:0]             wb_dest,
    input  logic                   ex_allow_in,
    output logic                   id_to_ex_valid,
    output logic [ID_EX_BUS_W-1:0] id_to_ex_bus
);

    logic [IF_ID_BUS_W-1:0] if_bus_p0;
    logic [31:0]            inst;
    logic [DATA_W-1:0]      pc;
    logic [CTRL_W-1:0]      ctrl;
    logic [DATA_W-1:0]      imm;
    logic                   rs1_used, rs2_used, rd_used;
    logic [4:0]             rs1, rs2, rd;
    logic                   hazard, stall, id_ready;
    logic                   br_cond, br_redirect, br_taken;
    logic [DATA_W-1:0]      jalr_sum, br_target;
    logic signed [DATA_W-1:0] rs1_s, rs2_s;

    assign inst = if_bus_p0[63:32];
    assign pc   = if_bus_p0[31:0];
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];
    assign rd   = rd_used ? inst[11:7] : 5'd0;

    id_decoder u_decoder (
        .inst     (inst),
        .ctrl     (ctrl),
        .imm      (imm),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .rd_used  (rd_used)
    );

    function automatic logic dest_hit(input logic [5:0] dest, input logic [4:0] src);
        return dest[5] && (dest[4:0] != 5'd0) && (dest[4:0] == src);
    endfunction

    assign hazard = (rs1_used && (rs1 != 5'd0) &&
                     (dest_hit(ex_dest, rs1) || dest_hit(mem_dest, rs1) || dest_hit(wb_dest, rs1)))
                 || (rs2_used && (rs2 != 5'd0) &&
                     (dest_hit(ex_dest, rs2) || dest_hit(mem_dest, rs2) || dest_hit(wb_dest, rs2)));

    assign stall          = id_valid && hazard;
    assign id_ready       = ~stall;
    assign id_allow_in    = !id_valid || (id_ready && ex_allow_in);
    assign id_to_ex_valid = id_valid && id_ready;

    assign rs1_s = rf_rdata1;
    assign rs2_s = rf_rdata2;

    always_comb begin
        case (inst[14:12])
            F3_BEQ:  br_cond = (rf_rdata1 == rf_rdata2);
            F3_BNE:  br_cond = (rf_rdata1 != rf_rdata2);
            F3_BLT:  br_cond = (rs1_s < rs2_s);
            F3_BGE:  br_cond = (rs1_s >= rs2_s);
            F3_BLTU: br_cond = (rf_rdata1 < rf_rdata2);
            F3_BGEU: br_cond = (rf_rdata1 >= rf_rdata2);
            default: br_cond = 1'b0;
        endcase
    end

    assign br_redirect = ctrl[CTRL_JAL] || ctrl[CTRL_JALR] || (ctrl[CTRL_BRANCH] && br_cond);
    // A redirect is only meaningful when EX actually takes the instruction; reset suppresses it.
    assign br_taken    = !rst && id_to_ex_valid && ex_allow_in && br_redirect;
    assign jalr_sum    = rf_rdata1 + imm;
    assign br_target   = ctrl[CTRL_JALR] ? {jalr_sum[DATA_W-1:1], 1'b0} : pc + imm;
    assign br_bus      = {br_taken, br_target};

    assign rf_raddr1    = rs1;
    assign rf_raddr2    = rs2;
    assign id_to_ex_bus = {ctrl, rd, rf_rdata2, rf_rdata1, imm, pc};

    // Stage p0: IF -> ID register; the wrong-path instruction is squashed on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
        end else if (id_allow_in) begin
            id_valid <= if_to_id_valid && !br_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (id_allow_in && if_to_id_valid) begin
            if_bus_p0 <= if_to_id_bus;
        end
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_to_id_valid  in  1  fetch stage presents an instruction.
REQ-004 if_to_id_bus  in  64  {inst[63:32], pc[31:0]}.
REQ-005 id_allow_in  out  1  ID accepts a new instruction this cycle.
REQ-006 id_valid  out  1  ID holds a live instruction.
REQ-007 br_bus  out  33  {br_taken, br_target[31:0]} redirect to fetch.
REQ-008 rf_raddr1, rf_raddr2  out  5 each  register-file read addresses (= rs1, rs2).
REQ-009 rf_rdata1, rf_rdata2  in  32 each  combinational register-file read data.
REQ-010 ex_dest, mem_dest, wb_dest  in  6 each  {valid, rd[4:0]} of downstream in-flight writers.
REQ-011 ex_allow_in  in  1  EX accepts this cycle.
REQ-012 id_to_ex_valid  out  1  ID hands an instruction to EX.
REQ-013 id_to_ex_bus  out  160  {ctrl[26:0], rd[4:0], rs2_val, rs1_val, imm, pc}, field layout fixed in package.

Function
REQ-014 id_ready SHALL equal ~stall; id_allow_in SHALL equal !id_valid || (id_ready && ex_allow_in); id_to_ex_valid SHALL equal id_valid && id_ready.
REQ-015 When id_allow_in is high, id_valid SHALL load if_to_id_valid, and the instruction/pc register SHALL load if_to_id_bus only if if_to_id_valid; otherwise both hold.
REQ-016 Decode SHALL cover RV32I LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; any other opcode SHALL decode as NOP (no register write, no branch, no memory access).
REQ-017 Immediates SHALL be sign-extended to 32 bits per format I/S/B/U/J; U-type uses inst[31:12]<<12.
REQ-018 rs1/rs2 are "used" per format; stall SHALL be asserted when id_valid, a used source is nonzero, and it equals rd of any of ex/mem/wb_dest with valid=1 and rd!=0.
REQ-019 Stall SHALL hold the instruction in ID; id_to_ex_valid stays low and no redirect is issued while stalled.
REQ-020 Branch compare SHALL use rf_rdata1/2: BEQ, BNE, BLT/BGE signed, BLTU/BGEU unsigned; funct3 010/011 SHALL be treated as not-taken.
REQ-021 Targets: B-type pc+immB, JAL pc+immJ, JALR (rs1_val+immI) with bit 0 cleared; arithmetic modulo 2^32.
REQ-022 br_taken SHALL be high only in the handoff cycle (id_to_ex_valid && ex_allow_in) of a taken branch, JAL or JALR; br_target is don't-care otherwise.
REQ-023 An instruction accepted in the same cycle br_taken is high SHALL be discarded (id_valid loads 0).
REQ-024 No delay slot: the instruction after a taken control transfer SHALL never reach EX.
REQ-025 id_to_ex_bus SHALL be valid whenever id_to_ex_valid is high; rs values taken from rf_rdata at handoff.

Reset
REQ-026 On rst: id_valid=0; so id_allow_in=1, id_to_ex_valid=0, br_taken=0 in the following cycle.
REQ-027 rst mid-stall or mid-handoff SHALL drop the held instruction with no redirect emitted.
REQ-028 Instruction/pc register need not be reset.

Structure
REQ-029 Package id_pkg SHALL hold bus widths (64, 33, 160), opcode/funct3 constants and ctrl field offsets, shared with IF/EX.
REQ-030 One combinational sub-module id_decoder (inst -> ctrl, imm, rs/rd-used flags); hazard, branch and handshake logic stay in id_stage.

Verification
REQ-031 ADDI x1,x0,5 at pc 0x0, no hazards -> id_to_ex_valid next cycle, imm=5, rd=1, br_taken=0.
REQ-032 ADD x3,x1,x2 with ex_dest={1,1} for 2 cycles -> stall 2 cycles, id_allow_in=0, handoff on cycle 3.
REQ-033 BEQ x1,x2,+16 at pc 0x100, rdata1=rdata2=7 -> br_bus={1,0x110}; same-cycle incoming instruction dropped.
REQ-034 JALR x0,x5,3 with rdata1=0x200 -> target 0x202; BLTU 0xFFFFFFFF vs 1 not taken, BLT taken.
REQ-035 Hazard on x0 (ex_dest={1,0}) -> no stall; ex_allow_in low 3 cycles -> instruction held, br_taken low until accept.
REQ-036 rst asserted during a stall -> id_valid=0 next cycle, no br_taken pulse.
